bayer_window_stream: RTL

Streaming 3x3 neighbourhood generator for the demosaic pipeline. It takes raster-order Bayer pixels over a valid/ready handshake and stores the two previous rows in internal line buffers. It emits one border-replicated 3x3 window per input pixel, tagged with x, y and Bayer colour type. It replaces the hand-wired shift-register, window and xy-counter chain with a single parametrised block. It adds backpressure, frame-end flush and selectable CFA phase.

---
 rtl/bayer_window_stream_if.sv | 37 +++
 rtl/bayer_window_stream.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bayer_window_stream_if.sv
// Bundles the pixel input stream and the 3x3 window output stream of bayer_window_stream.
// Latency: none, this is wiring only.
// Backpressure: s_ready/m_ready carry the valid/ready handshakes in each direction.
//
// Ports: s_valid/s_ready/s_data form the raster pixel stream into the block.
//        m_valid/m_ready/m_window/m_x/m_y/m_type/m_eol/m_last form the window stream out of it.
// Modports: slave is the window block's view; master is the surrounding pipeline's view.
interface bayer_window_stream_if #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12
) ();

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;

  logic                    m_valid;
  logic                    m_ready;
  logic [9*DATA_WIDTH-1:0] m_window;
  logic [X_WIDTH-1:0]      m_x;
  logic [Y_WIDTH-1:0]      m_y;
  logic [1:0]              m_type;
  logic                    m_eol;
  logic                    m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_window, m_x, m_y, m_type, m_eol, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_window, m_x, m_y, m_type, m_eol, m_last
  );

endinterface

// File: rtl/bayer_window_stream.sv
// Turns a raster Bayer pixel stream into one border-replicated 3x3 window per pixel, tagged with x/y/CFA colour.
// Latency: window k is valid the cycle after input pixel k+IMG_W+1 is accepted; the last IMG_W+1 windows drain in FLUSH.
// Backpressure: one registered output slot; s_ready drops while that slot is full and not being taken, and during FLUSH.
//
// Ports: clk, rst_n (async active-low); bus.slave carries s_valid/s_ready/s_data in and
//        m_valid/m_ready/m_window{tl..br, tl in MSBs}/m_x/m_y/m_type/m_eol/m_last out.
module bayer_window_stream #(
  parameter int DATA_WIDTH    = 12,
  parameter int IMG_W         = 1920,
  parameter int IMG_H         = 1080,
  parameter int X_WIDTH       = 12,
  parameter int Y_WIDTH       = 12,
  parameter int BAYER_PATTERN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bayer_window_stream_if.slave  bus
);

  localparam int                 AW     = $clog2(IMG_W);
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_W - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_H - 1);
  localparam logic [1:0]         PHASE  = 2'(BAYER_PATTERN);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // One image column of the 3-row neighbourhood.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] mid;
    logic [DATA_WIDTH-1:0] bot;
  } col_t;

  state_t                  state;
  logic [X_WIDTH-1:0]      in_x, out_x;
  logic [Y_WIDTH-1:0]      in_y, out_y;

  // lb0 holds the row above the incoming pixel, lb1 the row above that.
  logic [DATA_WIDTH-1:0]   lb0 [IMG_W];
  logic [DATA_WIDTH-1:0]   lb1 [IMG_W];

  // col_a/col_b are the two most recently shifted-in columns (col_b newest).
  col_t                    col_a, col_b;
  col_t                    col_new, col_l, col_r;
  logic [AW-1:0]           rd_addr;

  logic                    valid_q, eol_q, last_q;
  logic [9*DATA_WIDTH-1:0] win_q, win_n;
  logic [X_WIDTH-1:0]      x_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic [1:0]              type_q, type_n, cfa;

  logic                    in_fire, flush_step, advance, primed, load, in_last, out_hs;

  assign bus.s_ready  = (state == RUN) && (!valid_q || bus.m_ready);
  assign bus.m_valid  = valid_q;
  assign bus.m_window = win_q;
  assign bus.m_x      = x_q;
  assign bus.m_y      = y_q;
  assign bus.m_type   = type_q;
  assign bus.m_eol    = eol_q;
  assign bus.m_last   = last_q;

  always_comb begin
    in_fire    = bus.s_valid && bus.s_ready;
    out_hs     = valid_q && bus.m_ready;
    // During FLUSH the stream is continued with virtual pixels of rows IMG_H and IMG_H+1;
    // their bottom-row data is never selected because the last row clamps downward.
    flush_step = (state == FLUSH) && (!valid_q || (bus.m_ready && !last_q));
    advance    = in_fire || flush_step;
    // Centre lags the incoming pixel by one row and one column; nothing to emit before that.
    primed     = (in_y > Y_WIDTH'(1)) || ((in_y == Y_WIDTH'(1)) && (in_x != '0));
    load       = flush_step || (in_fire && primed);
    in_last    = (in_x == X_LAST) && (in_y == Y_LAST);

    rd_addr     = in_x[AW-1:0];
    col_new.top = lb1[rd_addr];
    col_new.mid = lb0[rd_addr];
    col_new.bot = (state == RUN) ? bus.s_data : lb0[rd_addr];

    // The centre column is always col_b. At the end of a line the incoming pixel
    // belongs to the next line, so the right column replicates the centre instead.
    col_l = (out_x == '0)    ? col_b : col_a;
    col_r = (out_x == X_LAST) ? col_b : col_new;

    win_n = {
      (out_y == '0)    ? {col_l.mid, col_b.mid, col_r.mid} : {col_l.top, col_b.top, col_r.top},
      {col_l.mid, col_b.mid, col_r.mid},
      (out_y == Y_LAST) ? {col_l.mid, col_b.mid, col_r.mid} : {col_l.bot, col_b.bot, col_r.bot}
    };

    cfa = {out_y[0] ^ PHASE[1], out_x[0] ^ PHASE[0]};
    case (cfa)
      2'b00:   type_n = 2'b00;
      2'b11:   type_n = 2'b10;
      default: type_n = 2'b01;
    endcase
  end

  // Line buffer RAM: no reset, stale rows are always clamped away.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb0[rd_addr] <= bus.s_data;
      lb1[rd_addr] <= lb0[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_x    <= '0;
      in_y    <= '0;
      out_x   <= '0;
      out_y   <= '0;
      col_a   <= '0;
      col_b   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= '0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (in_fire && in_last) state <= FLUSH;
        FLUSH:   if (out_hs && last_q) state <= RUN;
        default: state <= IDLE;
      endcase

      if (advance) begin
        col_a <= col_b;
        col_b <= col_new;
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= (in_y == Y_LAST) ? '0 : in_y + Y_WIDTH'(1);
        end else begin
          in_x <= in_x + X_WIDTH'(1);
        end
      end

      // Next frame starts clean once the final window has been taken.
      if (state == FLUSH && out_hs && last_q) begin
        in_x <= '0;
        in_y <= '0;
      end

      if (load) begin
        valid_q <= 1'b1;
        win_q   <= win_n;
        x_q     <= out_x;
        y_q     <= out_y;
        type_q  <= type_n;
        eol_q   <= (out_x == X_LAST);
        last_q  <= (out_x == X_LAST) && (out_y == Y_LAST);
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + Y_WIDTH'(1);
        end else begin
          out_x <= out_x + X_WIDTH'(1);
        end
      end else if (bus.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
